// File: rtl/ipm_red_pkg.sv
// ipm_red_pkg: shared constants and FSM state type for the IPM-RED blocks
package ipm_red_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/gf256_mult.sv
// gf256_mult: combinational GF(2^8) multiply modulo x^8+x^4+x^3+x+1
module gf256_mult
  import ipm_red_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] p
);
  logic [BYTE_W-1:0] t;
  always_comb begin
    p = '0;
    t = a;
    for (int i = 0; i < BYTE_W; i++) begin
      p = b[i] ? p ^ t : p;
      t = {t[BYTE_W-2:0], 1'b0} ^ (t[BYTE_W-1] ? GF_POLY : '0);
    end
  end
endmodule

// File: rtl/ipm_red_decode_check.sv
// ipm_red_decode_check: serial IPM-RED unmasking (x = <L1,P>) with redundancy check against <L2,P>
module ipm_red_decode_check
  import ipm_red_pkg::*;
#(
  parameter int V = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [V*BYTE_W-1:0]   P,
  input  logic [V*BYTE_W-1:0]   L1,
  input  logic [V*BYTE_W-1:0]   L2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_W-1:0]     x,
  output logic                  fault,
  output logic                  busy
);
  localparam int IW = $clog2(V);
  localparam logic [IW-1:0] LAST = IW'(V - 1);
  state_t state;
  logic [V*BYTE_W-1:0] p_r, l1_r, l2_r;
  logic [BYTE_W-1:0] acc1, acc2, prod1, prod2, acc1_n, acc2_n;
  logic [IW-1:0] idx;
  // captured vectors shift down one byte per cycle so the multipliers always see byte 0
  gf256_mult m1 (.a(l1_r[BYTE_W-1:0]), .b(p_r[BYTE_W-1:0]), .p(prod1));
  gf256_mult m2 (.a(l2_r[BYTE_W-1:0]), .b(p_r[BYTE_W-1:0]), .p(prod2));
  assign acc1_n = acc1 ^ prod1;
  assign acc2_n = acc2 ^ prod2;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      x         <= '0;
      fault     <= 1'b0;
      acc1      <= '0;
      acc2      <= '0;
      idx       <= '0;
      p_r       <= '0;
      l1_r      <= '0;
      l2_r      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          p_r      <= P;
          l1_r     <= L1;
          l2_r     <= L2;
          acc1     <= '0;
          acc2     <= '0;
          idx      <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= ACC;
        end
        ACC: begin
          acc1 <= acc1_n;
          acc2 <= acc2_n;
          p_r  <= p_r >> BYTE_W;
          l1_r <= l1_r >> BYTE_W;
          l2_r <= l2_r >> BYTE_W;
          idx  <= (idx == LAST) ? '0 : idx + 1'b1;
          if (idx == LAST) begin
            x         <= acc1_n;
            fault     <= acc1_n != acc2_n;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipm_red_decode_check.sv
// tb_ipm_red_decode_check: randomized and directed checks of two decoder instances (v=2, v=8) against a log/antilog GF model
module tb_ipm_red_decode_check;
  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] p = '0, l1 = '0, l2 = '0;
  logic iv[2], orr[2], ir[2], ov[2], flt[2], bsy[2];
  logic [7:0] xo[2];
  logic [7:0] exp_t[256];
  int log_t[256];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  ipm_red_decode_check #(.V(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .P(p[15:0]), .L1(l1[15:0]), .L2(l2[15:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .x(xo[0]), .fault(flt[0]), .busy(bsy[0])
  );
  ipm_red_decode_check #(.V(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .P(p), .L1(l1), .L2(l2),
    .out_valid(ov[1]), .out_ready(orr[1]), .x(xo[1]), .fault(flt[1]), .busy(bsy[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    return (a == 0 || b == 0) ? 8'h00 : exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction
  function automatic logic [7:0] ip(input logic [63:0] pp, input logic [63:0] ll, input int v);
    logic [7:0] d = 8'h00;
    for (int i = 0; i < v; i++) d ^= gmul(pp[8*i +: 8], ll[8*i +: 8]);
    return d;
  endfunction
  task automatic run(input int s, input logic [63:0] pp, input logic [63:0] a, input logic [63:0] b, input string tag);
    int v = s ? 8 : 2;
    int k = 0;
    while (!ir[s] && k < 50) begin @(negedge clk); k++; end
    check({tag, "_ready"}, ir[s], 1);
    p = pp; l1 = a; l2 = b; iv[s] = 1'b1;
    @(posedge clk); #1;
    iv[s] = 1'b0;
    p = {$urandom, $urandom}; l1 = {$urandom, $urandom}; l2 = {$urandom, $urandom};
    @(negedge clk);
    k = 0;
    while (!ov[s] && k < 40) begin @(negedge clk); k++; end
    check({tag, "_lat"}, k, v);
    check({tag, "_x"}, xo[s], ip(pp, a, v));
    check({tag, "_fault"}, flt[s], ip(pp, a, v) != ip(pp, b, v));
  endtask
  initial begin
    logic [7:0] e = 8'h01;
    logic [63:0] rp, ra, rb, m;
    logic [7:0] hx;
    logic hf;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e ^ {e[6:0], 1'b0} ^ (e[7] ? 8'h1B : 8'h00);
    end
    exp_t[255] = exp_t[0];
    log_t[0] = 0;
    iv[0] = 0; iv[1] = 0; orr[0] = 1; orr[1] = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ir[1], 1);
    check("rst_valid", ov[1], 0);
    check("rst_x", xo[1], 0);
    check("rst_fault", flt[1], 0);
    check("rst_busy", bsy[1], 0);
    run(0, 64'h5700, 64'h8301, 64'h8301, "basic");
    check("basic_c1", xo[0], 8'hC1);
    check("basic_nofault", flt[0], 0);
    run(0, 64'h5701, 64'h8301, 64'h8301, "share0");
    check("share0_c0", xo[0], 8'hC0);
    run(0, 64'h5700, 64'h8301, 64'h1301, "flt");
    check("flt_c1", xo[0], 8'hC1);
    check("flt_d2", ip(64'h5700, 64'h1301, 2), 8'hFE);
    check("flt_set", flt[0], 1);
    orr[1] = 1'b0;
    rp = {$urandom, $urandom}; ra = {$urandom, $urandom, 8'h01} ; rb = ra ^ 64'h0000_0400_0000_0000;
    run(1, rp, ra, rb, "bp");
    hx = ip(rp, ra, 8);
    hf = hx != ip(rp, rb, 8);
    for (int c = 0; c < 5; c++) begin
      iv[1] = 1'b1; p = {$urandom, $urandom};
      @(negedge clk);
      check("bp_valid", ov[1], 1);
      check("bp_ready", ir[1], 0);
      check("bp_x", xo[1], hx);
      check("bp_fault", flt[1], hf);
    end
    iv[1] = 1'b0; orr[1] = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", ov[1], 0);
    check("bp_rel_ready", ir[1], 1);
    p = {$urandom, $urandom}; l1 = {$urandom, $urandom}; l2 = l1; iv[1] = 1'b1;
    @(posedge clk); #1 iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_busy", bsy[1], 1);
    rst = 1'b1; iv[1] = 1'b1;
    @(posedge clk); #1 rst = 1'b0; iv[1] = 1'b0;
    @(negedge clk);
    check("mid_valid", ov[1], 0);
    check("mid_ready", ir[1], 1);
    check("mid_busy0", bsy[1], 0);
    run(1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, "post_rst");
    for (int t = 0; t < 1000; t++) begin
      rp = {$urandom, $urandom};
      ra = {$urandom, $urandom};
      ra[7:0] = 8'h01;
      m = 64'(8'($urandom_range(1, 255))) << (8 * $urandom_range(0, 7));
      rb = $urandom_range(0, 1) ? ra : ra ^ m;
      run(1, rp, ra, rb, "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
